// File: rtl/axi_lite_pkg.sv
// ============================================================================
// Module      : axi_lite_pkg
// Description : Shared AXI4-Lite types, response codes, FSM states and the
//               byte-strobe merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_lite_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [1:0]  resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ADDR = 2'd1,
        WR_DATA = 2'd2,
        WR_RESP = 2'd3
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Replace only the bytes whose strobe bit is set.
    function automatic data_t strb_merge(input data_t old_data,
                                         input data_t new_data,
                                         input strb_t strb);
        data_t merged;
        merged = old_data;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage : axi_lite_pkg

`default_nettype wire

// File: rtl/axi_lite_addr_decode.sv
// ============================================================================
// Module      : axi_lite_addr_decode
// Description : Maps a byte address onto the register bank: hit flag plus
//               word index. Byte-lane bits addr[1:0] do not matter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int    NUM_REGS  = 32,
    parameter addr_t BASE_ADDR = 32'h0000_0000,
    parameter int    IDX_W     = $clog2(NUM_REGS)
) (
    input  addr_t            addr,
    output logic             hit,
    output logic [IDX_W-1:0] index
);

    localparam addr_t c_span = addr_t'(NUM_REGS * 4);

    addr_t w_offset;

    // The lower-bound test stops wrap-around below BASE_ADDR from aliasing into the bank.
    assign w_offset = addr - BASE_ADDR;
    assign hit      = (addr >= BASE_ADDR) && (w_offset < c_span);
    assign index    = w_offset[2 +: IDX_W];

endmodule : axi_lite_addr_decode

`default_nettype wire

// File: rtl/axi_lite_slave_regs.sv
// ============================================================================
// Module      : axi_lite_slave_regs
// Description : AXI4-Lite slave holding NUM_REGS 32-bit registers, with
//               independent read and write FSMs and SLVERR on misses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int    NUM_REGS  = 32,
    parameter addr_t BASE_ADDR = 32'h0000_0000
) (
    input  logic  aclk,
    input  logic  areset_n,
    input  addr_t awaddr,
    input  logic  awvalid,
    output logic  awready,
    input  data_t wdata,
    input  strb_t wstrb,
    input  logic  wvalid,
    output logic  wready,
    output resp_t bresp,
    output logic  bvalid,
    input  logic  bready,
    input  addr_t araddr,
    input  logic  arvalid,
    output logic  arready,
    output data_t rdata,
    output resp_t rresp,
    output logic  rvalid,
    input  logic  rready
);

    localparam int c_idx_w = $clog2(NUM_REGS);

    data_t              r_regs [NUM_REGS];

    wr_state_t          r_wr_state;
    logic               r_aw_hit;
    logic [c_idx_w-1:0] r_aw_index;
    data_t              r_wdata;
    strb_t              r_wstrb;
    logic               r_bvalid;
    resp_t              r_bresp;

    rd_state_t          r_rd_state;
    data_t              r_rdata;
    resp_t              r_rresp;
    logic               r_rvalid;

    logic               w_aw_hit;
    logic [c_idx_w-1:0] w_aw_index;
    logic               w_ar_hit;
    logic [c_idx_w-1:0] w_ar_index;

    logic               w_awready;
    logic               w_wready;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_ar_hs;

    logic               w_commit;
    logic               w_commit_hit;
    logic [c_idx_w-1:0] w_commit_index;
    data_t              w_commit_data;
    strb_t              w_commit_strb;

    axi_lite_addr_decode #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (c_idx_w)
    ) u_aw_decode (
        .addr  (awaddr),
        .hit   (w_aw_hit),
        .index (w_aw_index)
    );

    axi_lite_addr_decode #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (c_idx_w)
    ) u_ar_decode (
        .addr  (araddr),
        .hit   (w_ar_hit),
        .index (w_ar_index)
    );

    // Readys are pure state decodes so they never depend on a valid.
    assign w_awready = (r_wr_state == WR_IDLE) || (r_wr_state == WR_DATA);
    assign w_wready  = (r_wr_state == WR_IDLE) || (r_wr_state == WR_ADDR);
    assign w_aw_hs   = awvalid && w_awready;
    assign w_w_hs    = wvalid && w_wready;
    assign w_ar_hs   = arvalid && (r_rd_state == RD_IDLE);

    assign awready = w_awready;
    assign wready  = w_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign arready = (r_rd_state == RD_IDLE);
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

    // Pick whichever half of the write arrives last from the live bus, the other from the latch.
    always_comb begin
        w_commit       = 1'b0;
        w_commit_hit   = 1'b0;
        w_commit_index = '0;
        w_commit_data  = r_wdata;
        w_commit_strb  = r_wstrb;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit       = 1'b1;
                    w_commit_hit   = w_aw_hit;
                    w_commit_index = w_aw_index;
                    w_commit_data  = wdata;
                    w_commit_strb  = wstrb;
                end
            end
            WR_ADDR: begin
                if (w_w_hs) begin
                    w_commit       = 1'b1;
                    w_commit_hit   = r_aw_hit;
                    w_commit_index = r_aw_index;
                    w_commit_data  = wdata;
                    w_commit_strb  = wstrb;
                end
            end
            WR_DATA: begin
                if (w_aw_hs) begin
                    w_commit       = 1'b1;
                    w_commit_hit   = w_aw_hit;
                    w_commit_index = w_aw_index;
                end
            end
            default: begin
                w_commit = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_wr_state <= WR_IDLE;
            r_aw_hit   <= 1'b0;
            r_aw_index <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_aw_hs && w_w_hs) begin
                        r_wr_state <= WR_RESP;
                    end else if (w_aw_hs) begin
                        r_aw_hit   <= w_aw_hit;
                        r_aw_index <= w_aw_index;
                        r_wr_state <= WR_ADDR;
                    end else if (w_w_hs) begin
                        r_wdata    <= wdata;
                        r_wstrb    <= wstrb;
                        r_wr_state <= WR_DATA;
                    end
                end
                WR_ADDR: begin
                    if (w_w_hs) begin
                        r_wr_state <= WR_RESP;
                    end
                end
                WR_DATA: begin
                    if (w_aw_hs) begin
                        r_wr_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        r_bvalid   <= 1'b0;
                        r_wr_state <= WR_IDLE;
                    end
                end
                default: begin
                    r_wr_state <= WR_IDLE;
                end
            endcase
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_commit_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && w_commit_hit) begin
            r_regs[w_commit_index] <= strb_merge(r_regs[w_commit_index],
                                                 w_commit_data, w_commit_strb);
        end
    end

    // Non-blocking capture means a same-edge write is not yet visible: read sees the old value.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_rd_state <= RD_IDLE;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_rvalid   <= 1'b0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata    <= w_ar_hit ? r_regs[w_ar_index] : '0;
                        r_rresp    <= w_ar_hit ? RESP_OKAY : RESP_SLVERR;
                        r_rvalid   <= 1'b1;
                        r_rd_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rready) begin
                        r_rvalid   <= 1'b0;
                        r_rd_state <= RD_IDLE;
                    end
                end
                default: begin
                    r_rd_state <= RD_IDLE;
                end
            endcase
        end
    end

endmodule : axi_lite_slave_regs

`default_nettype wire

// File: tb/tb_axi_lite_slave_regs.sv
// ============================================================================
// Module      : tb_axi_lite_slave_regs
// Description : Self-checking bench for axi_lite_slave_regs (32 registers).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_slave_regs;
    import axi_lite_pkg::*;

    logic  aclk;
    logic  areset_n;
    addr_t awaddr;
    logic  awvalid;
    logic  awready;
    data_t wdata;
    strb_t wstrb;
    logic  wvalid;
    logic  wready;
    resp_t bresp;
    logic  bvalid;
    logic  bready;
    addr_t araddr;
    logic  arvalid;
    logic  arready;
    data_t rdata;
    resp_t rresp;
    logic  rvalid;
    logic  rready;

    axi_lite_slave_regs #(
        .NUM_REGS  (32),
        .BASE_ADDR (32'h0000_0000)
    ) u_dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic  is_write;
        addr_t addr;
        data_t data;
        strb_t strb;
        int    w_lead;
        int    hold;
        data_t exp_data;
        resp_t exp_resp;
    } vec_t;

    typedef struct {
        data_t data;
        resp_t resp;
    } rexp_t;

    resp_t b_q[$];
    rexp_t r_q[$];

    int n_checks;
    int n_errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Collect one B response, optionally stalling bready first.
    task automatic collect_b(input int hold);
        resp_t exp;
        resp_t first;
        int    cyc;
        cyc = 0;
        while (!bvalid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("b_timeout", {63'd0, bvalid}, 64'd1);
        first = bresp;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("b_hold_valid", {63'd0, bvalid}, 64'd1);
            check("b_hold_resp", {62'd0, bresp}, {62'd0, first});
            check("b_hold_readys", {62'd0, awready, wready}, 64'd0);
        end
        if (b_q.size() == 0) begin
            check("b_queue_empty", 64'd1, 64'd0);
        end else begin
            exp = b_q.pop_front();
            check("bresp", {62'd0, bresp}, {62'd0, exp});
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("b_drop", {63'd0, bvalid}, 64'd0);
    endtask

    task automatic do_write(input addr_t a, input data_t d, input strb_t s,
                            input int w_lead, input int hold, input resp_t exp);
        int   aw_start;
        int   w_start;
        int   cyc;
        logic aw_done;
        logic w_done;
        logic aw_fire;
        logic w_fire;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        b_q.push_back(exp);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        awvalid = (aw_start == 0);
        wvalid  = (w_start == 0);
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            tick();
            cyc++;
            if (aw_fire) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_fire)  begin w_done  = 1'b1; wvalid  = 1'b0; end
            if (!aw_done && !awvalid && cyc >= aw_start) awvalid = 1'b1;
            if (!w_done && !wvalid && cyc >= w_start) wvalid = 1'b1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("w_handshakes", {62'd0, aw_done, w_done}, 64'd3);
        check("b_latency", {63'd0, bvalid}, 64'd1);
        collect_b(hold);
    endtask

    task automatic collect_r(input int hold);
        rexp_t exp;
        data_t first;
        for (int i = 0; i < hold; i++) begin
            first = rdata;
            tick();
            check("r_hold_valid", {63'd0, rvalid}, 64'd1);
            check("r_hold_data", {32'd0, rdata}, {32'd0, first});
            check("r_hold_arready", {63'd0, arready}, 64'd0);
        end
        if (r_q.size() == 0) begin
            check("r_queue_empty", 64'd1, 64'd0);
        end else begin
            exp = r_q.pop_front();
            check("rdata", {32'd0, rdata}, {32'd0, exp.data});
            check("rresp", {62'd0, rresp}, {62'd0, exp.resp});
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("r_drop", {63'd0, rvalid}, 64'd0);
    endtask

    task automatic do_read(input addr_t a, input int hold, input data_t exp_d, input resp_t exp_r);
        rexp_t e;
        e.data = exp_d;
        e.resp = exp_r;
        r_q.push_back(e);
        check("ar_ready_idle", {63'd0, arready}, 64'd1);
        araddr  = a;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("r_latency", {63'd0, rvalid}, 64'd1);
        collect_r(hold);
    endtask

    vec_t vecs[12];

    initial begin
        vec_t  v;
        rexp_t e;
        n_checks = 0;
        n_errors = 0;

        //              wr    addr          data          strb   lead hold exp_data      exp_resp
        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,        4'h0,  0,   0, 32'h0,        RESP_OKAY};
        vecs[1]  = '{1'b0, 32'h0000_007C, 32'h0,        4'h0,  0,   0, 32'h0,        RESP_OKAY};
        vecs[2]  = '{1'b1, 32'h0000_0008, 32'hDEADBEEF, 4'hF,  0,   0, 32'h0,        RESP_OKAY};
        vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0,        4'h0,  0,   0, 32'hDEADBEEF, RESP_OKAY};
        vecs[4]  = '{1'b1, 32'h0000_0008, 32'h11223344, 4'h5,  3,   0, 32'h0,        RESP_OKAY};
        vecs[5]  = '{1'b0, 32'h0000_0008, 32'h0,        4'h0,  0,   5, 32'hDE22BE44, RESP_OKAY};
        vecs[6]  = '{1'b1, 32'h0000_0080, 32'hFFFFFFFF, 4'hF,  0,   5, 32'h0,        RESP_SLVERR};
        vecs[7]  = '{1'b0, 32'h0000_0100, 32'h0,        4'h0,  0,   0, 32'h0,        RESP_SLVERR};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,        4'h0,  0,   0, 32'h0,        RESP_OKAY};
        vecs[9]  = '{1'b1, 32'h0000_007C, 32'hA5A5A5A5, 4'hF, -2,   0, 32'h0,        RESP_OKAY};
        vecs[10] = '{1'b0, 32'h0000_007E, 32'h0,        4'h0,  0,   0, 32'hA5A5A5A5, RESP_OKAY};
        vecs[11] = '{1'b1, 32'h0000_0010, 32'h00000001, 4'hF,  0,   0, 32'h0,        RESP_OKAY};

        areset_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (2) tick();
        check("rst_readys", {61'd0, awready, wready, arready}, 64'd7);
        check("rst_valids", {62'd0, bvalid, rvalid}, 64'd0);
        check("rst_rdata", {32'd0, rdata}, 64'd0);
        check("rst_resps", {60'd0, bresp, rresp}, 64'd0);
        areset_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            if (v.is_write) do_write(v.addr, v.data, v.strb, v.w_lead, v.hold, v.exp_resp);
            else            do_read(v.addr, v.hold, v.exp_data, v.exp_resp);
        end

        // Read capture and write commit to 0x10 on the same edge.
        b_q.push_back(RESP_OKAY);
        e.data = 32'h1;
        e.resp = RESP_OKAY;
        r_q.push_back(e);
        awaddr = 32'h10; wdata = 32'h2; wstrb = 4'hF; araddr = 32'h10;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("coll_bvalid", {63'd0, bvalid}, 64'd1);
        check("coll_rvalid", {63'd0, rvalid}, 64'd1);
        collect_r(0);
        collect_b(0);
        do_read(32'h10, 0, 32'h2, RESP_OKAY);

        // Reset while parked in WR_ADDR aborts the write.
        awaddr = 32'h10; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wr_addr_readys", {62'd0, awready, wready}, 64'd1);
        wdata = 32'hCAFEF00D; wstrb = 4'hF;
        areset_n = 1'b0;
        #2;
        check("abort_rst_bvalid", {63'd0, bvalid}, 64'd0);
        check("abort_rst_readys", {62'd0, awready, wready}, 64'd3);
        tick();
        areset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_bvalid", {63'd0, bvalid}, 64'd0);
        end
        do_read(32'h10, 0, 32'h0, RESP_OKAY);

        check("b_queue_drained", 64'(b_q.size()), 64'd0);
        check("r_queue_drained", 64'(r_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_axi_lite_slave_regs

`default_nettype wire

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
AXI4-Lite responder (slave end) that terminates the interconnect's slave modport. It holds a bank of NUM_REGS 32-bit registers that masters read and write over the five AXI4-Lite channels. Read and write paths run as independent FSMs. Out-of-range accesses return SLVERR and have no side effects.

Parameters:
NUM_REGS, 32, number of 32-bit registers; must be a power of 2, minimum 2.
BASE_ADDR, 32'h0000_0000, byte address of register 0; must be aligned to NUM_REGS*4.

Ports:
aclk  input  1  clock; all logic is rising-edge.
areset_n  input  1  asynchronous active-low reset.
awaddr  input  addr_t (32)  write address.
awvalid  input  1  write address valid.
awready  output  1  write address ready.
wdata  input  data_t (32)  write data.
wstrb  input  strb_t (4)  byte enables; wstrb[i] covers wdata[8i+7:8i].
wvalid  input  1  write data valid.
wready  output  1  write data ready.
bresp  output  resp_t (2)  write response.
bvalid  output  1  write response valid.
bready  input  1  write response ready.
araddr  input  addr_t (32)  read address.
arvalid  input  1  read address valid.
arready  output  1  read address ready.
rdata  output  data_t (32)  read data.
rresp  output  resp_t (2)  read response.
rvalid  output  1  read data valid.
rready  input  1  read data ready.

Behaviour:
- Reset (areset_n low, asynchronous): all registers = 0; both FSMs go to IDLE; bvalid=0, rvalid=0, bresp=OKAY, rresp=OKAY, rdata=0; awready=1, wready=1, arready=1 (combinational from state).
- Reset mid-transaction aborts it. A pending write is not committed and no response is issued after reset.
- Address decode: offset = addr - BASE_ADDR. In range when addr >= BASE_ADDR and offset < NUM_REGS*4. Index = offset[2 +: $clog2(NUM_REGS)]. addr[1:0] is ignored.
- Write FSM states: WR_IDLE (awready=1, wready=1), WR_ADDR (address latched; wready=1, awready=0), WR_DATA (data and strobe latched; awready=1, wready=0), WR_RESP (bvalid=1, both readys 0).
- WR_IDLE transitions:
  - AW and W handshake in the same cycle -> WR_RESP.
  - AW only -> WR_ADDR.
  - W only -> WR_DATA.
- WR_ADDR goes to WR_RESP on the W handshake. WR_DATA goes to WR_RESP on the AW handshake.
- Commit: on the edge that completes the second handshake, write each byte whose strobe bit is set, if the address is in range. bvalid rises the next cycle. bresp = OKAY (2'b00) when in range, SLVERR (2'b10) when out of range; out-of-range writes leave the bank unchanged.
- WR_RESP: bvalid and bresp hold stable until bready. On bvalid && bready, go to WR_IDLE; bvalid drops the next cycle. Minimum throughput is one write per 2 cycles.
- Read FSM states: RD_IDLE (arready=1, rvalid=0), RD_DATA (arready=0, rvalid=1).
- On an arvalid && arready edge, capture rdata (the register value, or 0 if out of range) and rresp (OKAY or SLVERR), then go to RD_DATA. Latency is 1 cycle from AR handshake to rvalid.
- RD_DATA: rdata and rresp hold until rready; on rvalid && rready, go to RD_IDLE.
- Simultaneous read capture and write commit to the same register in one cycle: the read returns the pre-write value. The write takes effect as normal.
- Readys never depend combinationally on valids. Valids never drop before their handshake completes.

Decomposition:
- axi_lite_pkg holds the shared definitions: addr_t, data_t, strb_t, resp_t, and constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- Also add to axi_lite_pkg: wr_state_t and rd_state_t enums, and the function strb_merge(old, new, strb) -> data_t.
- One natural sub-module, axi_lite_addr_decode: combinational address -> {hit, index}. It is instantiated twice, once for AR and once for AW.

Test Plan:
- Reset, then read 0x0 and 0x7C -> rdata=0, rresp=OKAY; arready=awready=wready=1 during reset.
- AW=0x08 and W=0xDEADBEEF with strb=4'hF in the same cycle -> bvalid next cycle with OKAY; read 0x08 -> 0xDEADBEEF.
- W=0x11223344 with strb=4'b0101 three cycles before AW=0x08 -> bvalid one cycle after AW; read 0x08 -> 0xDE22BE44.
- AW=0x80 (out of range, NUM_REGS=32) -> bresp=SLVERR and bank unchanged; read 0x100 -> rresp=SLVERR, rdata=0.
- Hold bready=0 for 5 cycles -> bvalid/bresp stable, awready=wready=0; hold rready=0 -> rdata stable, arready=0.
- AR and the write commit to 0x10 (old 0x1, new 0x2) in the same cycle -> read returns 0x1; next read returns 0x2. Separately, assert areset_n low while in WR_ADDR -> no bvalid, register unchanged.
